// File: rtl/qr_result_packer.sv
// Packs one four-element signed QR result into two 32-bit stream words (LO then HI),
// with frame-end marking. Optional start-of-frame user flag: QR_PACK_USER_SOF_EN.
module qr_result_packer #(
    parameter int TBITS       = 32,
    parameter int TBYTE       = 4,
    parameter int DATA_LENGTH = 13,
    parameter int NUM_COL     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_LENGTH*4-1:0] res_data,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic [TBITS-1:0]         osif_data_din,
    output logic [TBYTE-1:0]         osif_strb_din,
    output logic                     osif_last_din,
    output logic                     osif_user_din,
    input  logic                     osif_full_n,
    output logic                     osif_write
);

    localparam int CNT_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_COL - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [DATA_LENGTH*4-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                     xfer_s;
    logic                     write_s;
    logic [31:0]              word_s;

    function automatic logic [15:0] sext16(input logic [DATA_LENGTH-1:0] e);
        sext16 = 16'($signed(e));
    endfunction

    assign res_ready     = (state_q == ST_IDLE) || ((state_q == ST_HI) && osif_full_n);
    assign write_s       = ((state_q == ST_LO) || (state_q == ST_HI)) && osif_full_n;
    assign xfer_s        = res_valid && res_ready;
    assign osif_write    = write_s;
    assign osif_strb_din = {TBYTE{1'b1}};

    // Next-state, hold-register capture and frame counter advance
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        if (xfer_s) begin
            hold_d = res_data;
        end else begin
            hold_d = hold_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) state_d = ST_LO;
                else        state_d = ST_IDLE;
            end
            ST_LO: begin
                if (osif_full_n) state_d = ST_HI;
                else             state_d = ST_LO;
            end
            ST_HI: begin
                if (osif_full_n && xfer_s)  state_d = ST_LO;
                else if (osif_full_n)       state_d = ST_IDLE;
                else                        state_d = ST_HI;
            end
            default: state_d = ST_IDLE;
        endcase
        if (write_s && (state_q == ST_HI)) begin
            if (frame_cnt_q == CNT_MAX) frame_cnt_d = {CNT_W{1'b0}};
            else                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Stream word selection; outputs are forced to zero when no write happens
    always_comb begin
        word_s        = 32'h0000_0000;
        osif_data_din = {TBITS{1'b0}};
        osif_last_din = 1'b0;
        osif_user_din = 1'b0;
        case (state_q)
            ST_LO:   word_s = {sext16(hold_q[2*DATA_LENGTH-1 -: DATA_LENGTH]),
                               sext16(hold_q[DATA_LENGTH-1 -: DATA_LENGTH])};
            ST_HI:   word_s = {sext16(hold_q[4*DATA_LENGTH-1 -: DATA_LENGTH]),
                               sext16(hold_q[3*DATA_LENGTH-1 -: DATA_LENGTH])};
            default: word_s = 32'h0000_0000;
        endcase
        if (write_s) begin
            osif_data_din = TBITS'(word_s);
            osif_last_din = (state_q == ST_HI) && (frame_cnt_q == CNT_MAX);
`ifdef QR_PACK_USER_SOF_EN
            osif_user_din = (state_q == ST_LO) && (frame_cnt_q == {CNT_W{1'b0}});
`else
            osif_user_din = 1'b0;
`endif
        end else begin
            osif_data_din = {TBITS{1'b0}};
            osif_last_din = 1'b0;
            osif_user_din = 1'b0;
        end
    end

    // State, hold register and frame counter flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= {(DATA_LENGTH*4){1'b0}};
            frame_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_qr_result_packer.sv
// Self-checking bench for qr_result_packer: vector table, hand sequences and a
// randomized run against a queue-based model of the expected word stream.
module tb_qr_result_packer;

    logic        clk;
    logic        rst;
    logic [51:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] osif_data_din;
    logic [3:0]  osif_strb_din;
    logic        osif_last_din;
    logic        osif_user_din;
    logic        osif_full_n;
    logic        osif_write;

    qr_result_packer #(.TBITS(32), .TBYTE(4), .DATA_LENGTH(13), .NUM_COL(8)) dut (
        .clk(clk), .rst(rst), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .osif_data_din(osif_data_din),
        .osif_strb_din(osif_strb_din), .osif_last_din(osif_last_din),
        .osif_user_din(osif_user_din), .osif_full_n(osif_full_n),
        .osif_write(osif_write)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } exp_t;

    typedef struct {
        logic [12:0] e0, e1, e2, e3;
        logic [31:0] lo, hi;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t mon_e;
    int   res_idx = 0;
    int   cyc = 0;
    int   wr_cnt, last_cnt, last_at, user_cnt, user_first, user_last, first_cyc, last_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // signed value of a 13-bit element, re-encoded as a 16-bit two's complement field
    function automatic logic [15:0] ref_sext(input int v);
        int s;
        s = (v >= 4096) ? v - 8192 : v;
        return 16'(s);
    endfunction

    task automatic push_result(input logic [51:0] r);
        exp_t lo, hi;
        lo.data = {ref_sext(int'(r[25:13])), ref_sext(int'(r[12:0]))};
        hi.data = {ref_sext(int'(r[51:39])), ref_sext(int'(r[38:26]))};
        lo.last = 1'b0;
        hi.last = ((res_idx % 8) == 7);
`ifdef QR_PACK_USER_SOF_EN
        lo.user = ((res_idx % 8) == 0);
`else
        lo.user = 1'b0;
`endif
        hi.user = 1'b0;
        q.push_back(lo);
        q.push_back(hi);
        res_idx++;
    endtask

    task automatic clear_counters();
        wr_cnt = 0; last_cnt = 0; last_at = 0; user_cnt = 0;
        user_first = 0; user_last = 0; first_cyc = 0; last_cyc = 0;
    endtask

    // Scoreboard: pending-word queue length decides expected ready/write each cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_ready", 32'(res_ready), 32'd1);
            chk("rst_write", 32'(osif_write), 32'd0);
            chk("rst_data", osif_data_din, 32'd0);
            chk("rst_last_user", 32'({osif_last_din, osif_user_din}), 32'd0);
            q.delete();
            res_idx = 0;
        end else begin
            chk("write", 32'(osif_write), 32'(q.size() > 0 && osif_full_n));
            chk("ready", 32'(res_ready), 32'(q.size() == 0 || (q.size() == 1 && osif_full_n)));
            chk("strb", 32'(osif_strb_din), 32'hF);
            if (osif_write) begin
                wr_cnt++;
                if (wr_cnt == 1) first_cyc = cyc;
                last_cyc = cyc;
                if (osif_last_din) begin last_cnt++; last_at = wr_cnt; end
                if (osif_user_din) begin
                    user_cnt++;
                    if (user_cnt == 1) user_first = wr_cnt;
                    user_last = wr_cnt;
                end
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    chk("sb_data", osif_data_din, mon_e.data);
                    chk("sb_last", 32'(osif_last_din), 32'(mon_e.last));
                    chk("sb_user", 32'(osif_user_din), 32'(mon_e.user));
                end
            end else begin
                chk("idle_data", osif_data_din, 32'd0);
                chk("idle_last_user", 32'({osif_last_din, osif_user_din}), 32'd0);
            end
            if (res_valid && res_ready) push_result(res_data);
        end
    end

    task automatic send_burst(input int n);
        int hs;
        logic [63:0] t;
        hs = 0;
        for (int c = 0; c < 8 * n + 20 && hs < n; c++) begin
            t = {$urandom, $urandom};
            res_data  = t[51:0];
            res_valid = 1'b1;
            @(negedge clk);
            if (res_ready) hs++;
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        chk("burst_accepts", 32'(hs), 32'(n));
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{13'h0001, 13'h1FFF, 13'h1000, 13'h0FFF, 32'hFFFF_0001, 32'h0FFF_F000};
        vt[1] = '{13'h0000, 13'h0000, 13'h0000, 13'h0000, 32'h0000_0000, 32'h0000_0000};
        vt[2] = '{13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vt[3] = '{13'h0FFF, 13'h0800, 13'h0ABC, 13'h1ABC, 32'h0800_0FFF, 32'hFABC_0ABC};
        vt[4] = '{13'h1234, 13'h0567, 13'h1001, 13'h0002, 32'h0567_F234, 32'h0002_F001};

        rst = 1'b1; res_valid = 1'b0; res_data = 52'd0; osif_full_n = 1'b1;
        clear_counters();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Eight back-to-back results: 16 consecutive writes, last only on the 16th
        clear_counters();
        send_burst(8);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_writes", 32'(wr_cnt), 32'd16);
        chk("b2b_last_cnt", 32'(last_cnt), 32'd1);
        chk("b2b_last_at", 32'(last_at), 32'd16);
        chk("b2b_span", 32'(last_cyc - first_cyc), 32'd15);

        // Fixed vectors with exact latency: LO one cycle after transfer, HI the next
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            res_data  = {vt[i].e3, vt[i].e2, vt[i].e1, vt[i].e0};
            res_valid = 1'b1;
            @(negedge clk);
            chk("vec_ready", 32'(res_ready), 32'd1);
            @(posedge clk); #1;
            res_valid = 1'b0;
            @(negedge clk);
            chk("vec_lo_write", 32'(osif_write), 32'd1);
            chk("vec_lo", osif_data_din, vt[i].lo);
            @(negedge clk);
            chk("vec_hi_write", 32'(osif_write), 32'd1);
            chk("vec_hi", osif_data_din, vt[i].hi);
            chk("vec_hi_last", 32'(osif_last_din), 32'd0);
        end

        // Back-pressure for five cycles while the LO word is pending
        @(posedge clk); #1;
        res_data    = {vt[0].e3, vt[0].e2, vt[0].e1, vt[0].e0};
        res_valid   = 1'b1;
        osif_full_n = 1'b0;
        @(negedge clk);
        chk("bp_accept", 32'(res_ready), 32'd1);
        @(posedge clk); #1;
        res_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_no_write", 32'(osif_write), 32'd0);
            chk("bp_not_ready", 32'(res_ready), 32'd0);
            @(posedge clk); #1;
        end
        osif_full_n = 1'b1;
        @(negedge clk);
        chk("bp_lo_write", 32'(osif_write), 32'd1);
        chk("bp_lo", osif_data_din, vt[0].lo);
        @(negedge clk);
        chk("bp_hi", osif_data_din, vt[0].hi);

        // Reset pulse three results into a frame, then two fresh frames
        @(posedge clk); #1;
        send_burst(3);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_write", 32'(osif_write), 32'd0);
        chk("midrst_data", osif_data_din, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_counters();
        send_burst(8);
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_last_cnt", 32'(last_cnt), 32'd1);
        chk("postrst_last_at", 32'(last_at), 32'd16);
        send_burst(8);
        repeat (4) @(posedge clk);
        #1;
        chk("two_frame_writes", 32'(wr_cnt), 32'd32);
        chk("two_frame_last_at", 32'(last_at), 32'd32);
`ifdef QR_PACK_USER_SOF_EN
        chk("user_cnt", 32'(user_cnt), 32'd2);
        chk("user_first", 32'(user_first), 32'd1);
        chk("user_last", 32'(user_last), 32'd17);
`else
        chk("user_cnt", 32'(user_cnt), 32'd0);
`endif

        // Randomized traffic with random back-pressure and rare resets
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] t;
            @(posedge clk); #1;
            t           = {$urandom, $urandom};
            res_data    = t[51:0];
            res_valid   = 1'($urandom_range(0, 1));
            osif_full_n = ($urandom_range(0, 9) < 7);
            rst         = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; res_valid = 1'b0; osif_full_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qr_result_packer.md
QR_RESULT_PACKER -- requirements
Module: qr_result_packer

Interface
REQ-001 SHALL have parameter TBITS, default 32, output stream word width.
REQ-002 SHALL have parameter TBYTE, default 4, strobe width (TBITS/8).
REQ-003 SHALL have parameter DATA_LENGTH, default 13, width of one signed QR result element.
REQ-004 SHALL have parameter NUM_COL, default 8, results per frame.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port res_data  input  DATA_LENGTH*4  QR result: e0=[12:0], e1=[25:13], e2=[38:26], e3=[51:39].
REQ-008 SHALL have port res_valid  input  1  res_data valid.
REQ-009 SHALL have port res_ready  output  1  block accepts res_data this cycle.
REQ-010 SHALL have port osif_data_din  output  TBITS  output stream data.
REQ-011 SHALL have port osif_strb_din  output  TBYTE  byte strobe.
REQ-012 SHALL have port osif_last_din  output  1  last word of frame.
REQ-013 SHALL have port osif_user_din  output  1  start-of-frame marker (see Configuration).
REQ-014 SHALL have port osif_full_n  input  1  downstream FIFO not full.
REQ-015 SHALL have port osif_write  output  1  write strobe into downstream FIFO.

Function
REQ-016 SHALL register one result into a hold register on res_valid && res_ready (transfer).
REQ-017 SHALL implement FSM states IDLE, LO, HI; IDLE->LO on transfer; LO->HI when osif_full_n=1; HI->LO if osif_full_n=1 and transfer; HI->IDLE if osif_full_n=1 and no transfer; otherwise hold state.
REQ-018 SHALL drive res_ready = (state==IDLE) || (state==HI && osif_full_n), combinational.
REQ-019 SHALL drive osif_write = (state==LO || state==HI) && osif_full_n; never write when osif_full_n=0.
REQ-020 SHALL emit in LO: {sext16(e1), sext16(e0)}; in HI: {sext16(e3), sext16(e2)}; each element sign-extended from DATA_LENGTH to 16 bits.
REQ-021 SHALL drive osif_data_din = 0 and osif_last_din = 0 whenever osif_write=0.
REQ-022 SHALL drive osif_strb_din = all ones constantly.
REQ-023 SHALL keep a frame counter 0..NUM_COL-1, incremented on each HI-word write, wrapping to 0 after NUM_COL-1.
REQ-024 SHALL assert osif_last_din on the HI-word write when frame counter == NUM_COL-1.
REQ-025 SHALL give latency: transfer in cycle N -> LO word earliest cycle N+1, HI word earliest N+2; sustained throughput one result per 2 cycles with no bubbles.
REQ-026 SHALL hold hold-register contents and state unchanged while osif_full_n=0 (back-pressure, no data loss or duplication).
REQ-027 SHALL ignore res_data when res_valid=0 or res_ready=0.

Reset
REQ-028 SHALL on rst: state=IDLE, hold register=0, frame counter=0, osif_write=0, osif_data_din=0, osif_last_din=0, osif_user_din=0; res_ready=1 (IDLE).
REQ-029 SHALL on rst asserted mid-frame discard the held result and partial frame; first result after release starts a new frame (counter 0).

Configuration
REQ-030 SHALL support macro QR_PACK_USER_SOF_EN: when defined, osif_user_din=1 on the LO-word write when frame counter==0, else 0; when undefined, osif_user_din tied 0 and no extra logic.

Verification
REQ-031 SHALL cover: reset, res_data e0=13'h0001, e1=13'h1FFF, e2=13'h1000, e3=13'h0FFF, osif_full_n=1 -> words 32'hFFFF_0001 then 32'h0FFF_F000, last=0.
REQ-032 SHALL cover: 8 back-to-back results with res_valid=1 -> 16 consecutive writes, res_ready high every second cycle, last=1 only on write 16.
REQ-033 SHALL cover: osif_full_n=0 for 5 cycles during LO -> no writes, res_ready=0, same LO word emitted once full_n returns.
REQ-034 SHALL cover: rst pulse after 3 results of a frame -> outputs zero, next 8 results end with last=1 on the 8th's HI word.
REQ-035 SHALL cover: with QR_PACK_USER_SOF_EN defined, 16 results -> osif_user_din=1 on writes 1 and 17 only; undefined -> always 0.
